// File: rtl/alu_seq_pkg.sv
// Shared op-code and FSM state definitions for the registered sequential ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOTA  = 3'b101,
    OP_MUL   = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_addw.sv
// W-bit ripple adder with carry in/out and two's-complement overflow.
module addw #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  // Overflow: operands share a sign that the result does not.
  assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/alu_seq.sv
// Registered W-bit ALU with start/busy/done handshake and a shift-add multiplier
// that produces a 2W-bit unsigned product in W cycles.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] r,
  output logic [W-1:0] r_hi,
  output logic         zero,
  output logic         c_out,
  output logic         sign,
  output logic         ovf
);

  localparam int CW = $clog2(W) + 1;

  state_e         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           take, mul_go, mul_step, mul_last;

  logic [W-1:0]   add_b, add_sum;
  logic           add_cin, add_cout, add_ovf;
  logic [W-1:0]   res;
  logic           res_c, res_v;

  logic [W-1:0]   mcand, mplier, acc_hi, acc_lo;
  logic [W-1:0]   mac_addend, mac_sum, hi_nxt, lo_nxt;
  logic           mac_cout, mac_ovf_unused;

  // SUB is a + ~b + 1, so the same adder serves both.
  assign add_b   = (op == OP_SUB) ? ~b : b;
  assign add_cin = (op == OP_SUB) ? 1'b1 : c_in;

  addw #(.W(W)) u_add (
    .a(a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_cout), .ovf(add_ovf)
  );

  assign mac_addend = mplier[0] ? mcand : '0;

  addw #(.W(W)) u_mac (
    .a(acc_hi), .b(mac_addend), .cin(1'b0), .sum(mac_sum), .cout(mac_cout), .ovf(mac_ovf_unused)
  );

  // The W+1-bit partial sum shifts right one place into the low half.
  assign hi_nxt = {mac_cout, mac_sum[W-1:1]};
  assign lo_nxt = {mac_sum[0], acc_lo[W-1:1]};

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res   = add_sum;
        res_c = add_cout;
        res_v = add_ovf;
      end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOTA:  res = ~a;
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    mul_go    = 1'b0;
    mul_step  = 1'b0;
    mul_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mul_go    = 1'b1;
            state_nxt = S_MUL;
          end else begin
            take = 1'b1;
          end
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (cnt == CW'(1)) begin
          mul_last  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_MUL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      r     <= '0;
      r_hi  <= '0;
      zero  <= 1'b1;
      c_out <= 1'b0;
      sign  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= take | mul_last;
      if (mul_go)
        cnt <= CW'(W);
      else if (mul_step)
        cnt <= cnt - CW'(1);
      if (take) begin
        r     <= res;
        r_hi  <= '0;
        zero  <= (res == '0);
        c_out <= res_c;
        sign  <= res[W-1];
        ovf   <= res_v;
      end else if (mul_last) begin
        r     <= lo_nxt;
        r_hi  <= hi_nxt;
        zero  <= ({hi_nxt, lo_nxt} == '0);
        c_out <= 1'b0;
        sign  <= hi_nxt[W-1];
        ovf   <= (hi_nxt != '0);
      end
    end
  end

  // Multiplier working registers are fully reloaded by every MUL start.
  always_ff @(posedge clk) begin
    if (mul_go) begin
      mcand  <= a;
      mplier <= b;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (mul_step) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at W=4, W=8 and W=2.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk, reset;

  logic start4, cin4, busy4, done4, zero4, cout4, sign4, ovf4;
  logic [2:0] op4;
  logic [3:0] a4, b4, r4, rhi4;

  logic start8, cin8, busy8, done8, zero8, cout8, sign8, ovf8;
  logic [2:0] op8;
  logic [7:0] a8, b8, r8, rhi8;

  logic start2, cin2, busy2, done2, zero2, cout2, sign2, ovf2;
  logic [2:0] op2;
  logic [1:0] a2, b2, r2, rhi2;

  int nchk = 0;
  int nerr = 0;
  int ndone;
  logic [7:0] rcap;

  alu_seq #(.W(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .op(op4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .r(r4), .r_hi(rhi4), .zero(zero4), .c_out(cout4),
    .sign(sign4), .ovf(ovf4)
  );

  alu_seq #(.W(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .r(r8), .r_hi(rhi8), .zero(zero8), .c_out(cout8),
    .sign(sign8), .ovf(ovf8)
  );

  alu_seq #(.W(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .a(a2), .b(b2), .c_in(cin2),
    .busy(busy2), .done(done2), .r(r2), .r_hi(rhi2), .zero(zero2), .c_out(cout2),
    .sign(sign2), .ovf(ovf2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go4(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y, input logic ci);
    op4 = o; a4 = x; b4 = y; cin4 = ci; start4 = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start4 = 0; op4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start2 = 0; op2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    tick(); tick();
    chk("rst_busy", busy4, 0);  chk("rst_done", done4, 0);
    chk("rst_r", r4, 0);        chk("rst_rhi", rhi4, 0);
    chk("rst_zero", zero4, 1);  chk("rst_cout", cout4, 0);
    chk("rst_sign", sign4, 0);  chk("rst_ovf", ovf4, 0);
    reset = 1'b0;
    tick();

    // ADD with carry in: 1+2+1
    go4(OP_ADD, 4'b0001, 4'b0010, 1'b1); tick(); start4 = 0;
    chk("addc_r", r4, 4'b0100); chk("addc_done", done4, 1);
    tick();

    // Reset two edges into a MUL
    go4(OP_MUL, 4'hF, 4'hF, 1'b0); tick(); start4 = 0;
    chk("rmul_busy", busy4, 1);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rmul_busy0", busy4, 0); chk("rmul_r", r4, 0);
    chk("rmul_rhi", rhi4, 0);    chk("rmul_zero", zero4, 1);
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4) ndone++;
    end
    chk("rmul_nodone", ndone, 0);

    // ADD 0111+1001 wraps to zero
    go4(OP_ADD, 4'b0111, 4'b1001, 1'b0); tick(); start4 = 0;
    chk("add1_r", r4, 4'b0000); chk("add1_cout", cout4, 1);
    chk("add1_zero", zero4, 1); chk("add1_ovf", ovf4, 0);
    chk("add1_sign", sign4, 0); chk("add1_done", done4, 1);
    tick();
    chk("add1_done_off", done4, 0); chk("add1_hold", r4, 4'b0000);

    go4(OP_ADD, 4'b0111, 4'b0001, 1'b0); tick(); start4 = 0;
    chk("add2_r", r4, 4'b1000); chk("add2_ovf", ovf4, 1);
    chk("add2_sign", sign4, 1); chk("add2_cout", cout4, 0);
    chk("add2_zero", zero4, 0);
    tick();

    // SUB, c_in ignored
    go4(OP_SUB, 4'b0011, 4'b0101, 1'b1); tick(); start4 = 0;
    chk("sub1_r", r4, 4'b1110); chk("sub1_cout", cout4, 0);
    chk("sub1_sign", sign4, 1); chk("sub1_ovf", ovf4, 0);
    tick();
    go4(OP_SUB, 4'b1000, 4'b0001, 1'b0); tick(); start4 = 0;
    chk("sub2_r", r4, 4'b0111); chk("sub2_ovf", ovf4, 1);
    chk("sub2_cout", cout4, 1);
    tick();

    // MUL 15*15 = 0xE1
    go4(OP_MUL, 4'hF, 4'hF, 1'b0); tick(); start4 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("mul1_busy", busy4, 1);
      chk("mul1_nodone", done4, 0);
      tick();
    end
    chk("mul1_busy0", busy4, 0); chk("mul1_done", done4, 1);
    chk("mul1_rhi", rhi4, 4'b1110); chk("mul1_r", r4, 4'b0001);
    chk("mul1_ovf", ovf4, 1); chk("mul1_sign", sign4, 1);
    chk("mul1_zero", zero4, 0); chk("mul1_cout", cout4, 0);
    tick();
    chk("mul1_done_off", done4, 0); chk("mul1_hold", rhi4, 4'b1110);

    // MUL 0*11
    go4(OP_MUL, 4'b0000, 4'b1011, 1'b0); tick(); start4 = 0;
    tick(); tick(); tick();
    chk("mul0_early", done4, 0);
    tick();
    chk("mul0_done", done4, 1); chk("mul0_r", r4, 0);
    chk("mul0_rhi", rhi4, 0);   chk("mul0_zero", zero4, 1);
    chk("mul0_ovf", ovf4, 0);
    tick();

    // ADD issued while busy is dropped; operands change mid-MUL
    go4(OP_MUL, 4'b0101, 4'b0011, 1'b0); tick();
    op4 = OP_ADD; a4 = 4'b0001; b4 = 4'b0001;
    tick(); start4 = 0;
    ndone = 0; rcap = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) begin
        ndone++;
        rcap = {rhi4, r4};
      end
      tick();
    end
    chk("drop_ndone", ndone, 1); chk("drop_prod", rcap, 8'h0F);
    chk("drop_r", r4, 4'b1111);  chk("drop_rhi", rhi4, 0);

    // Back-to-back XOR then NOTA, then AND/OR/PASSB
    go4(OP_XOR, 4'b1010, 4'b0110, 1'b0); tick();
    chk("xor_r", r4, 4'b1100); chk("xor_done", done4, 1);
    chk("xor_cout", cout4, 0); chk("xor_ovf", ovf4, 0);
    op4 = OP_NOTA; a4 = 4'b0000; tick();
    chk("nota_r", r4, 4'b1111); chk("nota_done", done4, 1);
    chk("nota_cout", cout4, 0); chk("nota_ovf", ovf4, 0);
    op4 = OP_AND; a4 = 4'b1100; b4 = 4'b1010; tick();
    chk("and_r", r4, 4'b1000);
    op4 = OP_OR; tick();
    chk("or_r", r4, 4'b1110);
    op4 = OP_PASSB; b4 = 4'b0101; tick(); start4 = 0;
    chk("passb_r", r4, 4'b0101); chk("passb_rhi", rhi4, 0);
    tick();
    chk("b2b_done_off", done4, 0);

    // W=8
    op8 = OP_XOR; a8 = 8'hAA; b8 = 8'h66; start8 = 1; tick();
    chk("w8_xor_r", r8, 8'hCC); chk("w8_xor_done", done8, 1);
    op8 = OP_NOTA; a8 = 8'h00; tick(); start8 = 0;
    chk("w8_nota_r", r8, 8'hFF); chk("w8_nota_done", done8, 1);
    chk("w8_nota_ovf", ovf8, 0); chk("w8_nota_cout", cout8, 0);
    tick();
    op8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01; cin8 = 0; start8 = 1; tick(); start8 = 0;
    chk("w8_add_r", r8, 8'h80); chk("w8_add_ovf", ovf8, 1);
    tick();
    op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF; start8 = 1; tick(); start8 = 0;
    for (int i = 0; i < 7; i++) tick();
    chk("w8_mul_busy", busy8, 1); chk("w8_mul_early", done8, 0);
    tick();
    chk("w8_mul_done", done8, 1); chk("w8_mul_rhi", rhi8, 8'hFE);
    chk("w8_mul_r", r8, 8'h01);   chk("w8_mul_ovf", ovf8, 1);
    tick();

    // W=2
    op2 = OP_XOR; a2 = 2'b10; b2 = 2'b11; start2 = 1; tick();
    chk("w2_xor_r", r2, 2'b01); chk("w2_xor_done", done2, 1);
    op2 = OP_NOTA; a2 = 2'b00; tick(); start2 = 0;
    chk("w2_nota_r", r2, 2'b11); chk("w2_nota_done", done2, 1);
    chk("w2_nota_cout", cout2, 0);
    tick();
    op2 = OP_MUL; a2 = 2'b11; b2 = 2'b11; start2 = 1; tick(); start2 = 0;
    tick();
    chk("w2_mul_busy", busy2, 1); chk("w2_mul_early", done2, 0);
    tick();
    chk("w2_mul_done", done2, 1); chk("w2_mul_rhi", rhi2, 2'b10);
    chk("w2_mul_r", r2, 2'b01);   chk("w2_mul_ovf", ovf2, 1);
    chk("w2_mul_sign", sign2, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
